router_rx_port: RTL and testbench

Packet receiver for one router output port; it sits directly downstream of `router_top` on a single `data_out_x`/`vld_out_x`/`read_enb_x` triple. It drains each packet from the port FIFO within the router's 30-cycle read window. It parses the header, streams the payload bytes out and checks address and parity. It reports per-packet status and a completed-packet count.

---
 rtl/router_rx_port_if.sv | 15 +
 rtl/router_rx_port.sv | 147 ++++++++++++++
 tb/tb_router_rx_port.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_rx_port_if.sv
`default_nettype none
// ============================================================================
// Module   : router_rx_port_if
// Brief    : Router output-port triple (data, FIFO-non-empty, read request).
// Revision : 1.0
// ============================================================================
interface router_rx_port_if;
    logic [7:0] data_out;
    logic       vld_out;
    logic       read_enb;

    modport master (output data_out, output vld_out, input read_enb);
    modport slave  (input data_out, input vld_out, output read_enb);
endinterface
`default_nettype wire

// File: rtl/router_rx_port.sv
`default_nettype none
// ============================================================================
// Module   : router_rx_port
// Brief    : Drains one router port, parses header/payload/parity, reports status.
// Revision : 1.0
// ============================================================================
module router_rx_port #(
    parameter logic [1:0] PORT_ADDR  = 2'b01,
    parameter int          READ_DELAY = 2,
    parameter int          TIMEOUT    = 64
) (
    input  logic              clock,
    input  logic              resetn,
    router_rx_port_if.slave   bus,
    output logic [7:0]        o_pyld_data,
    output logic              o_pyld_valid,
    output logic              o_pkt_done,
    output logic [5:0]        o_pkt_len,
    output logic [1:0]        o_pkt_addr,
    output logic              o_parity_err,
    output logic              o_addr_err,
    output logic              o_trunc_err,
    output logic [15:0]       o_pkt_count
);
    localparam int              c_IW        = $clog2(TIMEOUT);
    localparam logic [4:0]      c_DLY_INIT  = 5'(READ_DELAY);
    localparam logic [c_IW-1:0] c_IDLE_LAST = c_IW'(TIMEOUT - 1);
    localparam logic [c_IW-1:0] c_IDLE_ONE  = c_IW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DLY    = 3'd1,
        S_HDR_RD = 3'd2,
        S_HDR_WT = 3'd3,
        S_BODY   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          r_state, w_next;
    logic            r_rx_v;
    logic [4:0]      r_dly;
    logic [6:0]      r_req, r_exp;
    logic [c_IW-1:0] r_idle;
    logic [7:0]      r_acc;
    logic [5:0]      r_len;
    logic [1:0]      r_addr;
    logic [7:0]      r_pyld_data;
    logic            r_pyld_valid, r_trunc;
    logic [15:0]     r_pkt_count;
    logic            w_rd_active, w_read, w_timeout;

    // Abort only when no arrival is pending and the read gate is closed in the same cycle.
    assign w_timeout    = (r_state == S_BODY) && !r_rx_v && (r_idle == c_IDLE_LAST);
    assign w_read       = w_rd_active & bus.vld_out;
    assign bus.read_enb = w_read;

    always_comb begin
        w_next      = r_state;
        w_rd_active = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.vld_out) w_next = S_DLY;
            S_DLY:    if (r_dly == 5'd0) w_next = S_HDR_RD;
            S_HDR_RD: begin
                w_rd_active = 1'b1;
                if (bus.vld_out) w_next = S_HDR_WT;
            end
            S_HDR_WT: if (r_rx_v) w_next = S_BODY;
            S_BODY: begin
                w_rd_active = (r_req != 7'd0) && !w_timeout;
                if (r_rx_v && (r_exp == 7'd1)) w_next = S_DONE;
                else if (w_timeout)            w_next = S_IDLE;
            end
            S_DONE:   w_next = bus.vld_out ? S_DLY : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rx_v       <= 1'b0;
            r_dly        <= '0;
            r_req        <= '0;
            r_exp        <= '0;
            r_idle       <= '0;
            r_acc        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_pyld_data  <= '0;
            r_pyld_valid <= 1'b0;
            r_trunc      <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_rx_v       <= w_read;
            r_pyld_valid <= 1'b0;
            r_trunc      <= w_timeout;
            if (w_next == S_DLY && r_state != S_DLY)
                r_dly <= c_DLY_INIT;
            else if (r_state == S_DLY && r_dly != 5'd0)
                r_dly <= r_dly - 5'd1;
            case (r_state)
                S_HDR_WT: if (r_rx_v) begin
                    r_len  <= bus.data_out[7:2];
                    r_addr <= bus.data_out[1:0];
                    r_acc  <= bus.data_out;
                    r_req  <= {1'b0, bus.data_out[7:2]} + 7'd1;
                    r_exp  <= {1'b0, bus.data_out[7:2]} + 7'd1;
                    r_idle <= '0;
                end
                S_BODY: begin
                    if (w_read) r_req <= r_req - 7'd1;
                    if (r_rx_v) begin
                        r_exp  <= r_exp - 7'd1;
                        r_acc  <= r_acc ^ bus.data_out;
                        r_idle <= '0;
                        // The final expected arrival is the parity byte, not payload.
                        if (r_exp > 7'd1) begin
                            r_pyld_data  <= bus.data_out;
                            r_pyld_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + c_IDLE_ONE;
                    end
                end
                S_DONE:  r_pkt_count <= r_pkt_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign o_pkt_done   = (r_state == S_DONE);
    assign o_parity_err = o_pkt_done && (r_acc != 8'd0);
    assign o_addr_err   = o_pkt_done && (r_addr != PORT_ADDR);
    assign o_pyld_data  = r_pyld_data;
    assign o_pyld_valid = r_pyld_valid;
    assign o_pkt_len    = r_len;
    assign o_pkt_addr   = r_addr;
    assign o_trunc_err  = r_trunc;
    assign o_pkt_count  = r_pkt_count;
endmodule
`default_nettype wire

// File: tb/tb_router_rx_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_rx_port
// Brief    : Router FIFO model + scoreboard bench for router_rx_port.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_router_rx_port;
    localparam logic [1:0] PORT_ADDR  = 2'b01;
    localparam int         READ_DELAY = 2;
    localparam int         TIMEOUT    = 64;

    typedef struct { logic [7:0] data; bit hdr; } rbyte_t;
    typedef struct { int len; int addr; bit perr; bit aerr; int count; bit chk_lat; } stat_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  pyld_data;
    logic        pyld_valid, pkt_done, parity_err, addr_err, trunc_err;
    logic [5:0]  pkt_len;
    logic [1:0]  pkt_addr;
    logic [15:0] pkt_count;

    router_rx_port_if bus ();

    router_rx_port #(.PORT_ADDR(PORT_ADDR), .READ_DELAY(READ_DELAY), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus),
        .o_pyld_data  (pyld_data),
        .o_pyld_valid (pyld_valid),
        .o_pkt_done   (pkt_done),
        .o_pkt_len    (pkt_len),
        .o_pkt_addr   (pkt_addr),
        .o_parity_err (parity_err),
        .o_addr_err   (addr_err),
        .o_trunc_err  (trunc_err),
        .o_pkt_count  (pkt_count)
    );

    always #5 clock = ~clock;

    rbyte_t     rq[$];
    logic [7:0] exp_pyld[$];
    stat_t      exp_stat[$];
    int         hdr_cyc_q[$];
    int         exp_trunc = 0, exp_count = 0;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    int         rd_cnt = 0, done_cyc = 0, cnt_exp = 0;
    int         gap_cnt = 0, cool = 0;
    bit         pend = 0, b2b_pend = 0, cnt_chk = 0, rand_gaps = 0;
    rbyte_t     rb;
    stat_t      ms;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference packet: parity_err is exactly "was the parity byte corrupted".
    task automatic send_pkt(input int len, input int addr, input bit corrupt, input bit lat);
        logic [7:0] hdr, par, b;
        logic [5:0] l6;
        stat_t      s;
        l6  = 6'(len);
        hdr = {l6, 2'(addr)};
        par = hdr;
        rq.push_back('{hdr, 1'b1});
        for (int i = 0; i < len; i++) begin
            b   = 8'($urandom);
            par = par ^ b;
            rq.push_back('{b, 1'b0});
            exp_pyld.push_back(b);
        end
        if (corrupt) par = par ^ 8'h01;
        rq.push_back('{par, 1'b0});
        exp_count++;
        s.len = len; s.addr = addr; s.perr = corrupt;
        s.aerr = (2'(addr) != PORT_ADDR); s.count = exp_count; s.chk_lat = lat;
        exp_stat.push_back(s);
    endtask

    task automatic send_trunc(input int len, input int sent);
        logic [7:0] b;
        logic [5:0] l6;
        l6 = 6'(len);
        rq.push_back('{{l6, PORT_ADDR}, 1'b1});
        for (int i = 0; i < sent; i++) begin
            b = 8'($urandom);
            rq.push_back('{b, 1'b0});
            exp_pyld.push_back(b);
        end
        exp_trunc++;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((rq.size() != 0 || exp_pyld.size() != 0 || exp_stat.size() != 0 ||
                exp_trunc != 0 || cnt_chk) && n < budget) begin
            @(negedge clock); #3;
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d fifo bytes, %0d payload, %0d status, %0d trunc left after %0d cycles",
                     rq.size(), exp_pyld.size(), exp_stat.size(), exp_trunc, n);
        end
        repeat (8) @(negedge clock);
        #3;
    endtask

    // Router port FIFO: data appears the cycle after an issued read.
    always @(negedge clock) begin
        if (pend && rq.size() != 0) begin
            rb = rq.pop_front();
            bus.data_out = rb.data;
        end else begin
            bus.data_out = 8'($urandom);
        end
        pend = 0;
        if (rand_gaps) begin
            if (gap_cnt > 0) gap_cnt--;
            else if (cool > 0) cool--;
            else if ($urandom_range(0, 7) == 0) begin
                gap_cnt = int'($urandom_range(1, 15));
                cool    = 4;
            end
        end else begin
            gap_cnt = 0;
            cool    = 0;
        end
        bus.vld_out = (rq.size() != 0) && (gap_cnt == 0);
        #1;
        if (bus.read_enb) begin
            if (rq.size() == 0) begin
                check("read_on_empty_fifo", 1, 0);
            end else begin
                pend = 1;
                if (rq[0].hdr) begin
                    hdr_cyc_q.push_back(cyc);
                    rd_cnt = 1;
                    if (b2b_pend) begin
                        check("b2b_hdr_gap", cyc - done_cyc, READ_DELAY + 2);
                        b2b_pend = 0;
                    end
                end else begin
                    rd_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        int h;
        #2;
        if (cnt_chk) begin
            check("pkt_count_after_done", pkt_count, cnt_exp);
            cnt_chk = 0;
        end
        if (pyld_valid) begin
            if (exp_pyld.size() == 0) check("unexpected_pyld_valid", 1, 0);
            else check("pyld_data", pyld_data, exp_pyld.pop_front());
        end
        if (!pkt_done && (parity_err || addr_err))
            check("err_flag_outside_done", {parity_err, addr_err}, 0);
        if (pkt_done) begin
            if (exp_stat.size() == 0) begin
                check("unexpected_pkt_done", 1, 0);
            end else begin
                ms = exp_stat.pop_front();
                h  = (hdr_cyc_q.size() != 0) ? hdr_cyc_q.pop_front() : -1000;
                check("pkt_len", pkt_len, ms.len);
                check("pkt_addr", pkt_addr, ms.addr);
                check("parity_err", parity_err, ms.perr);
                check("addr_err", addr_err, ms.aerr);
                check("reads_per_pkt", rd_cnt, ms.len + 2);
                check("pkt_count_at_done", pkt_count, (ms.count - 1) & 16'hFFFF);
                if (ms.chk_lat) check("done_latency", cyc - h, ms.len + 4);
                cnt_chk = 1;
                cnt_exp = ms.count & 16'hFFFF;
                if (!rand_gaps && rq.size() != 0) begin
                    b2b_pend = 1;
                    done_cyc = cyc;
                end
            end
        end
        if (trunc_err) begin
            if (exp_trunc == 0) begin
                check("unexpected_trunc_err", 1, 0);
            end else begin
                check("trunc_without_done", pkt_done, 0);
                check("trunc_count_held", pkt_count, exp_count & 16'hFFFF);
                exp_trunc--;
                if (hdr_cyc_q.size() != 0) void'(hdr_cyc_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check("rst_read_enb", bus.read_enb, 0);
        check("rst_pyld_valid", pyld_valid, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_trunc_err", trunc_err, 0);
        resetn = 1'b1;

        send_pkt(14, 1, 0, 1);             wait_drain(400);
        check("count_after_first", pkt_count, 1);
        send_pkt(14, 1, 1, 1);             wait_drain(400);
        send_pkt(3, 2, 0, 1);              wait_drain(400);
        send_pkt(0, 1, 0, 1);              wait_drain(400);
        send_pkt(5, 1, 0, 1);
        send_pkt(9, 1, 0, 1);              wait_drain(600);
        check("b2b_gap_observed", b2b_pend, 0);

        rand_gaps = 1;
        for (int i = 0; i < 12; i++)
            send_pkt(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), 0);
        wait_drain(8000);
        rand_gaps = 0;

        send_trunc(10, 4);                 wait_drain(400);
        check("read_enb_after_abort", bus.read_enb, 0);
        send_pkt(6, 1, 0, 1);              wait_drain(400);

        send_pkt(30, 1, 0, 0);
        for (int n = 0; n < 300 && exp_pyld.size() > 25; n++) begin
            @(negedge clock); #3;
        end
        check("pyld_started_before_reset", (exp_pyld.size() <= 25), 1);
        @(negedge clock); #3;
        resetn = 1'b0;
        #1;
        check("midrst_read_enb", bus.read_enb, 0);
        check("midrst_pyld_valid", pyld_valid, 0);
        check("midrst_pyld_data", pyld_data, 0);
        check("midrst_pkt_done", pkt_done, 0);
        check("midrst_pkt_len", pkt_len, 0);
        check("midrst_pkt_addr", pkt_addr, 0);
        check("midrst_errs", {parity_err, addr_err, trunc_err}, 0);
        check("midrst_pkt_count", pkt_count, 0);
        rq.delete(); exp_pyld.delete(); exp_stat.delete(); hdr_cyc_q.delete();
        pend = 0; cnt_chk = 0; b2b_pend = 0; exp_count = 0; exp_trunc = 0;
        @(negedge clock); #3;
        resetn = 1'b1;
        send_pkt(2, 1, 0, 1);              wait_drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
